// File: rtl/mvb_reshaper_pkg.sv
`default_nettype none
// ============================================================================
// Module : mvb_reshaper_pkg
// Brief  : Shared types and helpers for the MVB reshaper. Provides the
//          count-width helper, the timeout-mode state enum and a popcount
//          function.
// Rev    : 1.0 - initial release
// ============================================================================
package mvb_reshaper_pkg;

  // Widest valid-mask the popcount helper accepts.
  localparam int c_max_vld_bits = 64;

  // Buffer occupancy classes, used only when MVB_RESHAPER_TIMEOUT_EN is set.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  // Bits needed to hold an item count of 0..items.
  function automatic int cnt_width(input int items);
    return $clog2(items + 1);
  endfunction

  function automatic int popcount(input logic [c_max_vld_bits-1:0] bits);
    int c;
    c = 0;
    for (int i = 0; i < c_max_vld_bits; i++) begin
      c = c + int'(bits[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvb_item_compactor.sv
`default_nettype none
// ============================================================================
// Module : mvb_item_compactor
// Brief  : Removes gaps from one multi-value word. Valid items are packed
//          into the low slots in ascending index order; unused slots are
//          zero. Also reports how many items were valid.
// Ports  : word_data   in  ITEMS*ITEM_WIDTH  raw word
//          word_vld    in  ITEMS             per-slot valid
//          packed_data out ITEMS*ITEM_WIDTH  gap-free items, low slots first
//          item_cnt    out CNT_W             number of valid items
// Rev    : 1.0 - initial release
// ============================================================================
module mvb_item_compactor
  import mvb_reshaper_pkg::*;
#(
  parameter int ITEMS      = 4,
  parameter int ITEM_WIDTH = 8,
  parameter int CNT_W      = 3
) (
  input  logic [ITEMS*ITEM_WIDTH-1:0] word_data,
  input  logic [ITEMS-1:0]            word_vld,
  output logic [ITEMS*ITEM_WIDTH-1:0] packed_data,
  output logic [CNT_W-1:0]            item_cnt
);

  // Each valid item lands in the slot equal to the number of valid items
  // below it. Comparing the running position against every slot keeps all
  // selects constant.
  always_comb begin
    int pos;
    pos         = 0;
    packed_data = '0;
    for (int i = 0; i < ITEMS; i++) begin
      if (word_vld[i]) begin
        for (int j = 0; j < ITEMS; j++) begin
          if (pos == j) begin
            packed_data[j*ITEM_WIDTH +: ITEM_WIDTH] = word_data[i*ITEM_WIDTH +: ITEM_WIDTH];
          end
        end
        pos = pos + 1;
      end
    end
  end

  assign item_cnt = CNT_W'(popcount(c_max_vld_bits'(word_vld)));

endmodule
`default_nettype wire

// File: rtl/mvb_reshaper.sv
`default_nettype none
// ============================================================================
// Module : mvb_reshaper
// Brief  : Re-packs a multi-value bus from RX_ITEMS to TX_ITEMS items per
//          word through an in-order item buffer of BUF_ITEMS entries.
//          Optional macro MVB_RESHAPER_TIMEOUT_EN holds back a partial TX
//          word for TIMEOUT cycles so it can fill up before being sent.
// Ports  : CLK, RESET (async, active high)
//          RX_DATA/RX_VLD/RX_SRC_RDY in,  RX_DST_RDY out
//          TX_DATA/TX_VLD/TX_SRC_RDY out, TX_DST_RDY in
// Rev    : 1.0 - initial release
// ============================================================================
module mvb_reshaper
  import mvb_reshaper_pkg::*;
#(
  parameter int RX_ITEMS   = 4,
  parameter int TX_ITEMS   = 2,
  parameter int ITEM_WIDTH = 8,
  parameter int BUF_ITEMS  = 8,
  parameter int TIMEOUT    = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [RX_ITEMS*ITEM_WIDTH-1:0] RX_DATA,
  input  logic [RX_ITEMS-1:0]            RX_VLD,
  input  logic                           RX_SRC_RDY,
  output logic                           RX_DST_RDY,
  output logic [TX_ITEMS*ITEM_WIDTH-1:0] TX_DATA,
  output logic [TX_ITEMS-1:0]            TX_VLD,
  output logic                           TX_SRC_RDY,
  input  logic                           TX_DST_RDY
);

  localparam int c_cnt_w    = cnt_width(BUF_ITEMS);
  localparam int c_rx_cnt_w = cnt_width(RX_ITEMS);

  // Slot 0 always holds the oldest item; slots at or above r_count are stale.
  logic [BUF_ITEMS*ITEM_WIDTH-1:0] r_buf, w_buf_next;
  logic [c_cnt_w-1:0]              r_count, w_count_next;
  logic                            r_rx_rdy, w_rx_rdy_next;

  logic [RX_ITEMS*ITEM_WIDTH-1:0]  w_rx_packed;
  logic [c_rx_cnt_w-1:0]           w_rx_cnt;
  logic [c_cnt_w-1:0]              w_tx_n, w_pop, w_push, w_base;
  logic                            w_tx_src_rdy, w_tx_xfer, w_rx_xfer;

  mvb_item_compactor #(
    .ITEMS      (RX_ITEMS),
    .ITEM_WIDTH (ITEM_WIDTH),
    .CNT_W      (c_rx_cnt_w)
  ) u_compactor (
    .word_data   (RX_DATA),
    .word_vld    (RX_VLD),
    .packed_data (w_rx_packed),
    .item_cnt    (w_rx_cnt)
  );

  assign w_tx_n    = (r_count < c_cnt_w'(TX_ITEMS)) ? r_count : c_cnt_w'(TX_ITEMS);
  assign w_tx_xfer = w_tx_src_rdy & TX_DST_RDY;
  assign w_rx_xfer = r_rx_rdy & RX_SRC_RDY;
  assign w_pop     = w_tx_xfer ? w_tx_n : '0;
  assign w_push    = w_rx_xfer ? c_cnt_w'(w_rx_cnt) : '0;
  assign w_base    = r_count - w_pop;

  // RX readiness guarantees room for a whole word, so this cannot overflow.
  assign w_count_next  = w_base + w_push;
  assign w_rx_rdy_next = (BUF_ITEMS - int'(w_count_next)) >= RX_ITEMS;

  // Shift out popped items, then append the compacted RX items right after
  // the survivors.
  always_comb begin
    w_buf_next = '0;
    for (int i = 0; i < BUF_ITEMS; i++) begin
      for (int p = 0; p <= TX_ITEMS && i + p < BUF_ITEMS; p++) begin
        if (int'(w_pop) == p) begin
          w_buf_next[i*ITEM_WIDTH +: ITEM_WIDTH] = r_buf[(i+p)*ITEM_WIDTH +: ITEM_WIDTH];
        end
      end
      for (int j = 0; j < RX_ITEMS; j++) begin
        if (j < int'(w_push) && int'(w_base) + j == i) begin
          w_buf_next[i*ITEM_WIDTH +: ITEM_WIDTH] = w_rx_packed[j*ITEM_WIDTH +: ITEM_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_buf    <= '0;
      r_count  <= '0;
      r_rx_rdy <= 1'b0;
    end else begin
      r_buf    <= w_buf_next;
      r_count  <= w_count_next;
      r_rx_rdy <= w_rx_rdy_next;
    end
  end

  assign RX_DST_RDY = r_rx_rdy;
  assign TX_SRC_RDY = w_tx_src_rdy;

  // TX view is a pure decode of the buffer head; empty slots read as zero.
  for (genvar s = 0; s < TX_ITEMS; s++) begin : g_tx_slot
    assign TX_VLD[s] = (int'(r_count) > s);
    assign TX_DATA[s*ITEM_WIDTH +: ITEM_WIDTH] =
      TX_VLD[s] ? r_buf[s*ITEM_WIDTH +: ITEM_WIDTH] : '0;
  end

`ifdef MVB_RESHAPER_TIMEOUT_EN
  localparam int c_tmr_w = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_next;
  logic [c_tmr_w-1:0] r_timer, w_timer_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= EMPTY;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  // The state tracks the occupancy class of the registered count.
  always_comb begin
    w_state_next = EMPTY;
    w_timer_next = '0;
    if (w_count_next == '0) begin
      w_state_next = EMPTY;
    end else if (w_count_next < c_cnt_w'(TX_ITEMS)) begin
      w_state_next = PARTIAL;
    end else begin
      w_state_next = FULL;
    end
    // Age the partial word only while it keeps waiting and stays partial.
    if (r_state == PARTIAL && !w_tx_xfer && w_state_next != FULL) begin
      w_timer_next = (r_timer == c_tmr_w'(TIMEOUT)) ? r_timer : r_timer + 1'b1;
    end
  end

  assign w_tx_src_rdy = (r_state == FULL) ||
                        (r_state == PARTIAL && r_timer == c_tmr_w'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_tx_src_rdy     = (r_count != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvb_reshaper.sv
`default_nettype none
// ============================================================================
// Module : tb_mvb_reshaper
// Brief  : Self-checking bench for mvb_reshaper (RX 4, TX 2, 8-bit items,
//          8-item buffer, timeout 3). Honours MVB_RESHAPER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mvb_reshaper;

  localparam int RX  = 4;
  localparam int TX  = 2;
  localparam int W   = 8;
  localparam int BUF = 8;
  localparam int TMO = 3;
`ifdef MVB_RESHAPER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [RX*W-1:0] rx_data;
  logic [RX-1:0]   rx_vld;
  logic            rx_src_rdy;
  logic            rx_dst_rdy;
  logic [TX*W-1:0] tx_data;
  logic [TX-1:0]   tx_vld;
  logic            tx_src_rdy;
  logic            tx_dst_rdy;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain FIFO of items plus the partial-word age.
  logic [W-1:0] mq[$];
  bit           m_rx_rdy = 1'b0;
  int           m_age = 0;
  longint       m_popped = 0;
  longint       dut_popped = 0;

  always #5 clk = ~clk;

  mvb_reshaper #(
    .RX_ITEMS   (RX),
    .TX_ITEMS   (TX),
    .ITEM_WIDTH (W),
    .BUF_ITEMS  (BUF),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .RX_DATA    (rx_data),
    .RX_VLD     (rx_vld),
    .RX_SRC_RDY (rx_src_rdy),
    .RX_DST_RDY (rx_dst_rdy),
    .TX_DATA    (tx_data),
    .TX_VLD     (tx_vld),
    .TX_SRC_RDY (tx_src_rdy),
    .TX_DST_RDY (tx_dst_rdy)
  );

  typedef struct {
    logic [RX*W-1:0] d;
    logic [RX-1:0]   v;
    bit              src;
    bit              dst;
    logic [TX-1:0]   e_vld;
    logic [TX*W-1:0] e_data;
    bit              e_src;
    bit              e_rdy;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int m_n();
    return (mq.size() < TX) ? mq.size() : TX;
  endfunction

  function automatic bit m_src();
    if (TMO_EN) return (mq.size() >= TX) || (mq.size() > 0 && m_age >= TMO);
    return mq.size() > 0;
  endfunction

  function automatic logic [TX*W-1:0] m_data();
    logic [TX*W-1:0] d;
    d = '0;
    for (int s = 0; s < m_n(); s++) d[s*W +: W] = mq[s];
    return d;
  endfunction

  function automatic logic [TX-1:0] m_vld();
    logic [TX-1:0] v;
    v = '0;
    for (int s = 0; s < m_n(); s++) v[s] = 1'b1;
    return v;
  endfunction

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int pre;
    int n;
    bit xfer;
    pre  = mq.size();
    n    = m_n();
    xfer = m_src() && tx_dst_rdy;
    if (xfer) begin
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      m_popped += n;
    end
    if (m_rx_rdy && rx_src_rdy) begin
      for (int i = 0; i < RX; i++) if (rx_vld[i]) mq.push_back(rx_data[i*W +: W]);
    end
    if (pre > 0 && pre < TX && !xfer && mq.size() < TX) m_age = (m_age < TMO) ? m_age + 1 : TMO;
    else m_age = 0;
    m_rx_rdy = (BUF - mq.size()) >= RX;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rx_rdy = 1'b0;
    m_age    = 0;
  endtask

  // Inputs are changed only at the falling edge; outputs are checked there.
  task automatic step();
    if (tx_src_rdy && tx_dst_rdy) dut_popped += $countones(tx_vld);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_src"}, 64'(tx_src_rdy), 64'(m_src()));
    check({tag, "_vld"}, 64'(tx_vld),     64'(m_vld()));
    check({tag, "_data"}, 64'(tx_data),   64'(m_data()));
    check({tag, "_rxrdy"}, 64'(rx_dst_rdy), 64'(m_rx_rdy));
  endtask

  task automatic drive(input logic [RX*W-1:0] d, input logic [RX-1:0] v, input bit src, input bit dst);
    rx_data    = d;
    rx_vld     = v;
    rx_src_rdy = src;
    tx_dst_rdy = dst;
  endtask

  task automatic drain(input string tag);
    drive('0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      step();
      check_model(tag);
    end
    check({tag, "_empty"}, 64'(tx_src_rdy), 64'(0));
    drive('0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'h04030201, 4'b0101, 1, 0, 2'b11, 16'h0301, 1, 1};
    tbl[1] = '{32'h0,        4'b0000, 0, 1, 2'b00, 16'h0000, 0, 1};
    tbl[2] = '{32'h44332211, 4'b1111, 1, 0, 2'b11, 16'h2211, 1, 1};
    tbl[3] = '{32'h88776655, 4'b1111, 1, 0, 2'b11, 16'h2211, 1, 0};
    tbl[4] = '{32'h0,        4'b0000, 0, 1, 2'b11, 16'h4433, 1, 0};
    tbl[5] = '{32'h0,        4'b0000, 0, 1, 2'b11, 16'h6655, 1, 1};
    tbl[6] = '{32'h0,        4'b0000, 0, 1, 2'b11, 16'h8877, 1, 1};
    tbl[7] = '{32'h0,        4'b0000, 0, 1, 2'b00, 16'h0000, 0, 1};

    drive('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_src",   64'(tx_src_rdy), 64'(0));
    check("rst_vld",   64'(tx_vld),     64'(0));
    check("rst_data",  64'(tx_data),    64'(0));
    check("rst_rxrdy", 64'(rx_dst_rdy), 64'(0));
    rst = 1'b0;
    step();
    check("post_rst_rxrdy", 64'(rx_dst_rdy), 64'(1));

    // Fixed vectors: compaction, fill to capacity, drain with backpressure.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].d, tbl[i].v, tbl[i].src, tbl[i].dst);
      step();
      check($sformatf("tbl%0d_vld", i),   64'(tx_vld),     64'(tbl[i].e_vld));
      check($sformatf("tbl%0d_data", i),  64'(tx_data),    64'(tbl[i].e_data));
      check($sformatf("tbl%0d_src", i),   64'(tx_src_rdy), 64'(tbl[i].e_src));
      check($sformatf("tbl%0d_rxrdy", i), 64'(rx_dst_rdy), 64'(tbl[i].e_rdy));
    end

    // Pop and push in the same cycle with three items buffered.
    drive(32'h00332211, 4'b0111, 1'b1, 1'b0);
    step();
    check("pp_fill_data", 64'(tx_data), 64'(16'h2211));
    drive(32'hA4A3A2A1, 4'b1111, 1'b1, 1'b1);
    step();
    check("pp_data",  64'(tx_data),    64'(16'hA133));
    check("pp_vld",   64'(tx_vld),     64'(2'b11));
    check("pp_rxrdy", 64'(rx_dst_rdy), 64'(0));
    drive('0, '0, 1'b0, 1'b1);
    step();
    check("pp_pop1_data",  64'(tx_data),    64'(16'hA3A2));
    check("pp_pop1_rxrdy", 64'(rx_dst_rdy), 64'(1));
    step();
    check("pp_pop2_data", 64'(tx_data),    64'(16'h00A4));
    check("pp_pop2_vld",  64'(tx_vld),     64'(2'b01));
    check("pp_pop2_src",  64'(tx_src_rdy), 64'(!TMO_EN));
    drain("pp_drain");

    // A single item: released at once, or after the timeout when enabled.
    drive(32'h005A0000, 4'b0100, 1'b1, 1'b0);
    step();
    drive('0, '0, 1'b0, 1'b0);
    check("one_vld",  64'(tx_vld),     64'(2'b01));
    check("one_data", 64'(tx_data),    64'(16'h005A));
    check("one_src0", 64'(tx_src_rdy), 64'(!TMO_EN));
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("one_src%0d", k), 64'(tx_src_rdy), 64'(TMO_EN ? (k == 3) : 1'b1));
    end
    check("one_vld_late", 64'(tx_vld), 64'(2'b01));
    drain("one_drain");

    // Reset asserted mid-cycle with five items buffered.
    drive(32'h14131211, 4'b1111, 1'b1, 1'b0);
    step();
    drive(32'h00000015, 4'b0001, 1'b1, 1'b0);
    step();
    drive('0, '0, 1'b0, 1'b0);
    check("rp_count5_data", 64'(tx_data), 64'(16'h1211));
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rp_src",   64'(tx_src_rdy), 64'(0));
    check("rp_vld",   64'(tx_vld),     64'(0));
    check("rp_data",  64'(tx_data),    64'(0));
    check("rp_rxrdy", 64'(rx_dst_rdy), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rp_after_src",   64'(tx_src_rdy), 64'(0));
    check("rp_after_vld",   64'(tx_vld),     64'(0));
    check("rp_after_rxrdy", 64'(rx_dst_rdy), 64'(1));
    drive(32'h00000077, 4'b0001, 1'b1, 1'b0);
    step();
    drive('0, '0, 1'b0, 1'b0);
    check("rp_new_data", 64'(tx_data), 64'(16'h0077));
    check("rp_new_vld",  64'(tx_vld),  64'(2'b01));
    drain("rp_drain");

    // Random valid masks and backpressure against the model.
    for (int c = 0; c < 10000; c++) begin
      int dst_pct;
      dst_pct = ((c / 1000) % 3 == 0) ? 20 : (((c / 1000) % 3 == 1) ? 90 : 55);
      drive($urandom, 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 99) < dst_pct);
      step();
      check_model("rnd");
    end
    drain("rnd_drain");
    check("rnd_item_total", 64'(dut_popped), 64'(m_popped));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvb_reshaper.md
MVB_RESHAPER -- requirements
Module: mvb_reshaper

Interface
REQ-001 SHALL have parameter RX_ITEMS, default 4, items per RX word.
REQ-002 SHALL have parameter TX_ITEMS, default 2, items per TX word.
REQ-003 SHALL have parameter ITEM_WIDTH, default 8, bits per item.
REQ-004 SHALL have parameter BUF_ITEMS, default 8, buffer capacity in items; must be >= max(RX_ITEMS, TX_ITEMS).
REQ-005 SHALL have parameter TIMEOUT, default 3, cycles a partial TX word waits (timeout feature only).
REQ-006 SHALL have ports: CLK in 1, the single clock; RESET in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: RX_DATA in RX_ITEMS*ITEM_WIDTH; RX_VLD in RX_ITEMS; RX_SRC_RDY in 1; RX_DST_RDY out 1.
REQ-008 SHALL have ports: TX_DATA out TX_ITEMS*ITEM_WIDTH; TX_VLD out TX_ITEMS; TX_SRC_RDY out 1; TX_DST_RDY in 1.

Function
REQ-009 SHALL transfer an RX word when RX_SRC_RDY=1 and RX_DST_RDY=1 on a rising CLK edge, and likewise a TX word when TX_SRC_RDY=1 and TX_DST_RDY=1.
REQ-010 SHALL append the valid items of an accepted RX word to the buffer in ascending index order, dropping invalid slots.
REQ-011 SHALL accept a word with RX_VLD all zero without changing state.
REQ-012 SHALL drive RX_DST_RDY=1 iff (BUF_ITEMS - count) >= RX_ITEMS, decoded from registers only; no combinational path from TX_DST_RDY.
REQ-013 SHALL present the n = min(count, TX_ITEMS) oldest items on TX_DATA slots 0..n-1, with TX_VLD thermometer-coded (low n bits set).
REQ-014 SHALL set unused TX_DATA slots to zero.
REQ-015 SHALL pop exactly n items on a TX transfer, oldest first; item order is preserved end to end.
REQ-016 SHALL handle a push and a pop in the same cycle: count_next = count - popped + pushed.
REQ-017 SHALL never exceed count = BUF_ITEMS and never underflow.
REQ-018 SHALL have latency of exactly 1 cycle: an item accepted at edge N is visible on TX after edge N.
REQ-019 SHALL hold TX_DATA, TX_VLD and TX_SRC_RDY stable while TX_SRC_RDY=1 and TX_DST_RDY=0, except for appending items into slots that are still empty.
REQ-020 SHALL, without the timeout feature, drive TX_SRC_RDY=1 iff count > 0.

Reset
REQ-021 SHALL, while RESET=1, asynchronously force count=0, TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, RX_DST_RDY=0 and timer=0.
REQ-022 SHALL discard all buffered items when RESET asserts mid-operation; none reappear after release.
REQ-023 SHALL raise RX_DST_RDY in the first cycle after RESET deasserts.

Configuration
REQ-024 SHALL support macro MVB_RESHAPER_TIMEOUT_EN.
REQ-025 SHALL, when MVB_RESHAPER_TIMEOUT_EN is defined, use states EMPTY (count=0), PARTIAL (0<count<TX_ITEMS) and FULL (count>=TX_ITEMS).
REQ-026 SHALL, with the macro, drive TX_SRC_RDY=1 in FULL, or in PARTIAL once timer==TIMEOUT.
REQ-027 SHALL, with the macro, increment the timer each cycle in PARTIAL (saturating at TIMEOUT), and clear it on EMPTY, on any TX transfer, or on entering FULL.
REQ-028 SHALL, when MVB_RESHAPER_TIMEOUT_EN is undefined, omit the timer and state logic entirely and follow REQ-020.

Structure
REQ-029 SHALL place the count-width constant ($clog2(BUF_ITEMS+1)), the state enum type and a popcount function in package mvb_reshaper_pkg.
REQ-030 SHALL place RX gap removal (compaction of valid items plus item count) in sub-module mvb_item_compactor; the buffer and TX logic stay in mvb_reshaper.

Verification (RX_ITEMS=4, TX_ITEMS=2, ITEM_WIDTH=8, BUF_ITEMS=8, TIMEOUT=3)
REQ-031 SHALL cover: RX DATA=0x04030201, VLD=0101 -> next cycle TX VLD=11, DATA=0x0301.
REQ-032 SHALL cover: two full RX words with TX_DST_RDY=0 -> count=8, RX_DST_RDY=0; after one TX transfer -> count=6, RX_DST_RDY still 0; after a second -> count=4, RX_DST_RDY=1.
REQ-033 SHALL cover: count=3, with a simultaneous TX pop and an RX push of 4 items -> count=5, order intact.
REQ-034 SHALL cover, with MVB_RESHAPER_TIMEOUT_EN: one item pushed -> TX_SRC_RDY stays 0 for 3 cycles, then rises with TX_VLD=01. Without the macro, it rises 1 cycle after the push.
REQ-035 SHALL cover: RESET pulse with count=5 -> TX_SRC_RDY=0 immediately, and no old items appear on TX after release.
REQ-036 SHALL cover: 10k random VLD/backpressure cycles -> scoreboard item order matches exactly, with no loss or duplication.
